// File: rtl/cpu_ctrl_pkg.sv
// Shared constants for the single-bus CPU control unit:
// opcodes, instruction classes, display codes and strobe bit positions.
package cpu_ctrl_pkg;

    localparam logic [4:0] OP_LD   = 5'd0;
    localparam logic [4:0] OP_LDI  = 5'd1;
    localparam logic [4:0] OP_ST   = 5'd2;
    localparam logic [4:0] OP_ADD  = 5'd3;
    localparam logic [4:0] OP_SUB  = 5'd4;
    localparam logic [4:0] OP_SHR  = 5'd5;
    localparam logic [4:0] OP_SHRA = 5'd6;
    localparam logic [4:0] OP_SHL  = 5'd7;
    localparam logic [4:0] OP_ROR  = 5'd8;
    localparam logic [4:0] OP_ROL  = 5'd9;
    localparam logic [4:0] OP_AND  = 5'd10;
    localparam logic [4:0] OP_OR   = 5'd11;
    localparam logic [4:0] OP_ADDI = 5'd12;
    localparam logic [4:0] OP_ANDI = 5'd13;
    localparam logic [4:0] OP_ORI  = 5'd14;
    localparam logic [4:0] OP_MUL  = 5'd15;
    localparam logic [4:0] OP_DIV  = 5'd16;
    localparam logic [4:0] OP_NEG  = 5'd17;
    localparam logic [4:0] OP_NOT  = 5'd18;
    localparam logic [4:0] OP_BR   = 5'd19;
    localparam logic [4:0] OP_JR   = 5'd20;
    localparam logic [4:0] OP_JAL  = 5'd21;
    localparam logic [4:0] OP_IN   = 5'd22;
    localparam logic [4:0] OP_OUT  = 5'd23;
    localparam logic [4:0] OP_MFHI = 5'd24;
    localparam logic [4:0] OP_MFLO = 5'd25;
    localparam logic [4:0] OP_NOP  = 5'd26;
    localparam logic [4:0] OP_HALT = 5'd27;

    localparam logic [4:0] ALU_ADD = 5'b00011;
    localparam logic [4:0] ALU_AND = 5'b01010;
    localparam logic [4:0] ALU_OR  = 5'b01011;

    localparam logic [3:0] CL_ALU3   = 4'h1;
    localparam logic [3:0] CL_ALUI   = 4'h2;
    localparam logic [3:0] CL_ALU2   = 4'h3;
    localparam logic [3:0] CL_MULDIV = 4'h4;
    localparam logic [3:0] CL_LD     = 4'h5;
    localparam logic [3:0] CL_LDI    = 4'h6;
    localparam logic [3:0] CL_ST     = 4'h7;
    localparam logic [3:0] CL_BR     = 4'h8;
    localparam logic [3:0] CL_JR     = 4'h9;
    localparam logic [3:0] CL_JAL    = 4'hA;
    localparam logic [3:0] CL_MOVE   = 4'hB;
    localparam logic [3:0] CL_NOP    = 4'hC;

    localparam logic [7:0] ST_RESET = 8'h00;
    localparam logic [7:0] ST_T0    = 8'h01;
    localparam logic [7:0] ST_T1    = 8'h02;
    localparam logic [7:0] ST_T2    = 8'h03;
    localparam logic [7:0] ST_PAUSE = 8'hFE;
    localparam logic [7:0] ST_HALT  = 8'hFF;

    localparam int CTRL_W    = 24;
    localparam int C_GRA     = 23;
    localparam int C_GRB     = 22;
    localparam int C_GRC     = 21;
    localparam int C_RIN     = 20;
    localparam int C_ROUT    = 19;
    localparam int C_BAOUT   = 18;
    localparam int C_PCIN    = 17;
    localparam int C_PCOUT   = 16;
    localparam int C_IRIN    = 15;
    localparam int C_MARIN   = 14;
    localparam int C_MDRIN   = 13;
    localparam int C_MDROUT  = 12;
    localparam int C_YIN     = 11;
    localparam int C_ZIN     = 10;
    localparam int C_ZHIGH   = 9;
    localparam int C_ZLOW    = 8;
    localparam int C_HIIN    = 7;
    localparam int C_LOIN    = 6;
    localparam int C_HIOUT   = 5;
    localparam int C_LOOUT   = 4;
    localparam int C_COUT    = 3;
    localparam int C_INPORT  = 2;
    localparam int C_OUTPORT = 1;
    localparam int C_CONIN   = 0;

    typedef enum logic [2:0] {
        PH_RST,
        PH_F0,
        PH_F1,
        PH_F2,
        PH_EX,
        PH_PAUSE,
        PH_HALT
    } phase_t;

    function automatic logic [3:0] last_step(input logic [3:0] cls);
        logic [3:0] s;
        s = 4'd3;
        case (cls)
            CL_ALU3, CL_ALUI, CL_LDI: s = 4'd5;
            CL_ALU2, CL_JAL:          s = 4'd4;
            CL_MULDIV, CL_BR:         s = 4'd6;
            CL_LD, CL_ST:             s = 4'd7;
            default:                  s = 4'd3;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/instr_decoder.sv
// Opcode to instruction class and ALU operation.
// Purely combinational; unknown opcodes fall into the NOP class.
module instr_decoder
    import cpu_ctrl_pkg::*;
(
    input  logic [4:0] i_opcode,
    output logic [3:0] o_class,
    output logic [4:0] o_alu_op
);

    always_comb begin
        o_class  = CL_NOP;
        o_alu_op = 5'd0;
        unique case (i_opcode)
            OP_ADD, OP_SUB, OP_SHR, OP_SHRA, OP_SHL,
            OP_ROR, OP_ROL, OP_AND, OP_OR: begin
                o_class  = CL_ALU3;
                o_alu_op = i_opcode;
            end
            OP_ADDI: begin
                o_class  = CL_ALUI;
                o_alu_op = ALU_ADD;
            end
            OP_ANDI: begin
                o_class  = CL_ALUI;
                o_alu_op = ALU_AND;
            end
            OP_ORI: begin
                o_class  = CL_ALUI;
                o_alu_op = ALU_OR;
            end
            OP_NEG, OP_NOT: begin
                o_class  = CL_ALU2;
                o_alu_op = i_opcode;
            end
            OP_MUL, OP_DIV: begin
                o_class  = CL_MULDIV;
                o_alu_op = i_opcode;
            end
            OP_LD: begin
                o_class  = CL_LD;
                o_alu_op = ALU_ADD;
            end
            OP_LDI: begin
                o_class  = CL_LDI;
                o_alu_op = ALU_ADD;
            end
            OP_ST: begin
                o_class  = CL_ST;
                o_alu_op = ALU_ADD;
            end
            OP_BR: begin
                o_class  = CL_BR;
                o_alu_op = ALU_ADD;
            end
            OP_JR:  o_class = CL_JR;
            OP_JAL: o_class = CL_JAL;
            OP_IN, OP_OUT, OP_MFHI, OP_MFLO: o_class = CL_MOVE;
            OP_NOP, OP_HALT: o_class = CL_NOP;
            default: o_class = CL_NOP;
        endcase
    end

endmodule

// File: rtl/control_unit.sv
// Moore sequencer for the single-bus CPU: fetch, decode, execute,
// pause at instruction boundaries and halt.
module control_unit
    import cpu_ctrl_pkg::*;
#(
    parameter int MEM_WAIT = 0,
    parameter int WAIT_W   = 4
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic        Stop,
    input  logic [31:0] IR,
    input  logic        CON_FF,
    output logic [23:0] ctrl,
    output logic [4:0]  alu_op,
    output logic        Read,
    output logic        Write,
    output logic        IncPC,
    output logic        Run,
    output logic [7:0]  present_state
);

    phase_t            r_phase;
    logic [3:0]        r_step;
    logic [WAIT_W-1:0] r_wait;
    logic              r_stop_pending;

    phase_t            w_next_phase;
    logic [3:0]        w_next_step;
    logic [4:0]        w_opcode;
    logic [3:0]        w_class;
    logic [4:0]        w_alu;
    logic              w_mem_step;
    logic              w_next_mem;
    logic              w_wait_done;
    logic              w_advance;
    logic              w_stay;
    logic              w_unused;

    assign w_opcode = IR[31:27];
    assign w_unused = ^IR[26:0];

    instr_decoder u_dec (
        .i_opcode (w_opcode),
        .o_class  (w_class),
        .o_alu_op (w_alu)
    );

    assign w_wait_done = (r_wait == '0);
    assign w_mem_step  = (r_phase == PH_F1) ||
                         (r_phase == PH_EX &&
                          ((w_class == CL_LD && r_step == 4'd6) ||
                           (w_class == CL_ST && r_step == 4'd7)));
    assign w_advance   = !w_mem_step || w_wait_done;
    assign w_stay      = w_mem_step && !w_wait_done;

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            r_phase <= PH_RST;
            r_step  <= 4'd0;
        end else begin
            r_phase <= w_next_phase;
            r_step  <= w_next_step;
        end
    end

    always_comb begin
        w_next_phase = r_phase;
        w_next_step  = r_step;
        unique case (r_phase)
            PH_RST: w_next_phase = PH_F0;
            PH_F0:  w_next_phase = PH_F1;
            PH_F1: begin
                if (w_advance) w_next_phase = PH_F2;
            end
            PH_F2: begin
                if (w_opcode == OP_HALT) begin
                    w_next_phase = PH_HALT;
                end else begin
                    w_next_phase = PH_EX;
                    w_next_step  = 4'd3;
                end
            end
            PH_EX: begin
                if (w_advance) begin
                    if (r_step >= last_step(w_class)) begin
                        w_next_phase = (r_stop_pending || Stop) ?
                                       PH_PAUSE : PH_F0;
                        w_next_step  = 4'd0;
                    end else begin
                        w_next_step = r_step + 4'd1;
                    end
                end
            end
            PH_PAUSE: begin
                if (!Stop) w_next_phase = PH_F0;
            end
            PH_HALT: w_next_phase = PH_HALT;
            default: w_next_phase = PH_RST;
        endcase
        w_next_mem = (w_next_phase == PH_F1) ||
                     (w_next_phase == PH_EX &&
                      ((w_class == CL_LD && w_next_step == 4'd6) ||
                       (w_class == CL_ST && w_next_step == 4'd7)));
    end

    // Counter is reloaded whenever a memory step is entered afresh.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            r_wait <= '0;
        end else if (w_stay) begin
            r_wait <= r_wait - WAIT_W'(1);
        end else if (w_next_mem) begin
            r_wait <= WAIT_W'(MEM_WAIT);
        end
    end

    // Stop held while paused is the hold request, not a new pause.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            r_stop_pending <= 1'b0;
        end else if (r_phase == PH_PAUSE ||
                     w_next_phase == PH_PAUSE) begin
            r_stop_pending <= 1'b0;
        end else if (Stop) begin
            r_stop_pending <= 1'b1;
        end
    end

    always_comb begin
        ctrl  = '0;
        Read  = 1'b0;
        Write = 1'b0;
        IncPC = 1'b0;
        unique case (r_phase)
            PH_F0: begin
                ctrl[C_PCOUT] = 1'b1;
                ctrl[C_MARIN] = 1'b1;
                IncPC         = 1'b1;
            end
            PH_F1: begin
                Read          = 1'b1;
                ctrl[C_MDRIN] = w_wait_done;
            end
            PH_F2: begin
                ctrl[C_MDROUT] = 1'b1;
                ctrl[C_IRIN]   = 1'b1;
            end
            PH_EX: begin
                unique case (w_class)
                    CL_ALU3, CL_ALUI: begin
                        unique case (r_step)
                            4'd3: begin
                                ctrl[C_GRB]  = 1'b1;
                                ctrl[C_ROUT] = 1'b1;
                                ctrl[C_YIN]  = 1'b1;
                            end
                            4'd4: begin
                                ctrl[C_ZIN] = 1'b1;
                                if (w_class == CL_ALU3) begin
                                    ctrl[C_GRC]  = 1'b1;
                                    ctrl[C_ROUT] = 1'b1;
                                end else begin
                                    ctrl[C_COUT] = 1'b1;
                                end
                            end
                            4'd5: begin
                                ctrl[C_ZLOW] = 1'b1;
                                ctrl[C_GRA]  = 1'b1;
                                ctrl[C_RIN]  = 1'b1;
                            end
                            default: ;
                        endcase
                    end
                    CL_ALU2: begin
                        if (r_step == 4'd3) begin
                            ctrl[C_GRB]  = 1'b1;
                            ctrl[C_ROUT] = 1'b1;
                            ctrl[C_ZIN]  = 1'b1;
                        end else begin
                            ctrl[C_ZLOW] = 1'b1;
                            ctrl[C_GRA]  = 1'b1;
                            ctrl[C_RIN]  = 1'b1;
                        end
                    end
                    CL_MULDIV: begin
                        unique case (r_step)
                            4'd3: begin
                                ctrl[C_GRA]  = 1'b1;
                                ctrl[C_ROUT] = 1'b1;
                                ctrl[C_YIN]  = 1'b1;
                            end
                            4'd4: begin
                                ctrl[C_GRB]  = 1'b1;
                                ctrl[C_ROUT] = 1'b1;
                                ctrl[C_ZIN]  = 1'b1;
                            end
                            4'd5: begin
                                ctrl[C_ZLOW] = 1'b1;
                                ctrl[C_LOIN] = 1'b1;
                            end
                            4'd6: begin
                                ctrl[C_ZHIGH] = 1'b1;
                                ctrl[C_HIIN]  = 1'b1;
                            end
                            default: ;
                        endcase
                    end
                    CL_LD, CL_LDI, CL_ST: begin
                        unique case (r_step)
                            4'd3: begin
                                ctrl[C_GRB]   = 1'b1;
                                ctrl[C_BAOUT] = 1'b1;
                                ctrl[C_YIN]   = 1'b1;
                            end
                            4'd4: begin
                                ctrl[C_COUT] = 1'b1;
                                ctrl[C_ZIN]  = 1'b1;
                            end
                            4'd5: begin
                                ctrl[C_ZLOW] = 1'b1;
                                if (w_class == CL_LDI) begin
                                    ctrl[C_GRA] = 1'b1;
                                    ctrl[C_RIN] = 1'b1;
                                end else begin
                                    ctrl[C_MARIN] = 1'b1;
                                end
                            end
                            4'd6: begin
                                if (w_class == CL_LD) begin
                                    Read          = 1'b1;
                                    ctrl[C_MDRIN] = w_wait_done;
                                end else begin
                                    ctrl[C_GRA]   = 1'b1;
                                    ctrl[C_ROUT]  = 1'b1;
                                    ctrl[C_MDRIN] = 1'b1;
                                end
                            end
                            4'd7: begin
                                if (w_class == CL_LD) begin
                                    ctrl[C_MDROUT] = 1'b1;
                                    ctrl[C_GRA]    = 1'b1;
                                    ctrl[C_RIN]    = 1'b1;
                                end else begin
                                    Write = 1'b1;
                                end
                            end
                            default: ;
                        endcase
                    end
                    CL_BR: begin
                        unique case (r_step)
                            4'd3: begin
                                ctrl[C_GRA]   = 1'b1;
                                ctrl[C_ROUT]  = 1'b1;
                                ctrl[C_CONIN] = 1'b1;
                            end
                            4'd4: begin
                                ctrl[C_PCOUT] = 1'b1;
                                ctrl[C_YIN]   = 1'b1;
                            end
                            4'd5: begin
                                ctrl[C_COUT] = 1'b1;
                                ctrl[C_ZIN]  = 1'b1;
                            end
                            4'd6: begin
                                ctrl[C_ZLOW] = CON_FF;
                                ctrl[C_PCIN] = CON_FF;
                            end
                            default: ;
                        endcase
                    end
                    CL_JR: begin
                        ctrl[C_GRA]  = 1'b1;
                        ctrl[C_ROUT] = 1'b1;
                        ctrl[C_PCIN] = 1'b1;
                    end
                    CL_JAL: begin
                        if (r_step == 4'd3) begin
                            ctrl[C_PCOUT] = 1'b1;
                            ctrl[C_GRB]   = 1'b1;
                            ctrl[C_RIN]   = 1'b1;
                        end else begin
                            ctrl[C_GRA]  = 1'b1;
                            ctrl[C_ROUT] = 1'b1;
                            ctrl[C_PCIN] = 1'b1;
                        end
                    end
                    CL_MOVE: begin
                        ctrl[C_GRA] = 1'b1;
                        unique case (w_opcode)
                            OP_IN: begin
                                ctrl[C_INPORT] = 1'b1;
                                ctrl[C_RIN]    = 1'b1;
                            end
                            OP_OUT: begin
                                ctrl[C_ROUT]    = 1'b1;
                                ctrl[C_OUTPORT] = 1'b1;
                            end
                            OP_MFHI: begin
                                ctrl[C_HIOUT] = 1'b1;
                                ctrl[C_RIN]   = 1'b1;
                            end
                            default: begin
                                ctrl[C_LOOUT] = 1'b1;
                                ctrl[C_RIN]   = 1'b1;
                            end
                        endcase
                    end
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

    assign alu_op = ctrl[C_ZIN] ? w_alu : 5'd0;

    assign Run = !(r_phase == PH_RST ||
                   r_phase == PH_PAUSE ||
                   r_phase == PH_HALT);

    always_comb begin
        present_state = ST_RESET;
        unique case (r_phase)
            PH_F0:    present_state = ST_T0;
            PH_F1:    present_state = ST_T1;
            PH_F2:    present_state = ST_T2;
            PH_EX:    present_state = {w_class, r_step};
            PH_PAUSE: present_state = ST_PAUSE;
            PH_HALT:  present_state = ST_HALT;
            default:  present_state = ST_RESET;
        endcase
    end

endmodule

// File: tb/tb_control_unit.sv
// Bench for control_unit: two instances (MEM_WAIT 0 and 2) checked
// cycle by cycle against per-instruction step tables built here.
module tb_control_unit;

    localparam int B_GRA = 23, B_GRB = 22, B_GRC = 21, B_RIN = 20;
    localparam int B_ROUT = 19, B_BAOUT = 18, B_PCIN = 17, B_PCOUT = 16;
    localparam int B_IRIN = 15, B_MARIN = 14, B_MDRIN = 13, B_MDROUT = 12;
    localparam int B_YIN = 11, B_ZIN = 10, B_ZHI = 9, B_ZLO = 8;
    localparam int B_HIIN = 7, B_LOIN = 6, B_HIOUT = 5, B_LOOUT = 4;
    localparam int B_COUT = 3, B_INP = 2, B_OUTP = 1, B_CONIN = 0;

    typedef struct packed {
        logic [7:0]  st;
        logic [23:0] c;
        logic [4:0]  alu;
        logic        rd;
        logic        wr;
        logic        inc;
        logic        run;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n [2];
    logic        stop  [2];
    logic [31:0] ir    [2];
    logic        con   [2];
    logic [23:0] o_ctl [2];
    logic [4:0]  o_alu [2];
    logic        o_rd  [2];
    logic        o_wr  [2];
    logic        o_inc [2];
    logic        o_run [2];
    logic [7:0]  o_ps  [2];

    int   total = 0;
    int   bad = 0;
    int   mw = 0;
    logic pend = 1'b0;
    exp_t q[$];

    always #5 clk = ~clk;

    control_unit #(.MEM_WAIT(0), .WAIT_W(4)) u_d0 (
        .Clock(clk), .Reset(rst_n[0]), .Stop(stop[0]), .IR(ir[0]),
        .CON_FF(con[0]), .ctrl(o_ctl[0]), .alu_op(o_alu[0]),
        .Read(o_rd[0]), .Write(o_wr[0]), .IncPC(o_inc[0]),
        .Run(o_run[0]), .present_state(o_ps[0])
    );

    control_unit #(.MEM_WAIT(2), .WAIT_W(4)) u_d2 (
        .Clock(clk), .Reset(rst_n[1]), .Stop(stop[1]), .IR(ir[1]),
        .CON_FF(con[1]), .ctrl(o_ctl[1]), .alu_op(o_alu[1]),
        .Read(o_rd[1]), .Write(o_wr[1]), .IncPC(o_inc[1]),
        .Run(o_run[1]), .present_state(o_ps[1])
    );

    function automatic logic [23:0] bm(input int i);
        return 24'(1) << i;
    endfunction

    function automatic exp_t mk(input logic [7:0] st, input logic [23:0] c,
                                input logic [4:0] alu, input logic rd,
                                input logic wr, input logic inc,
                                input logic run);
        exp_t e;
        e.st = st; e.c = c; e.alu = alu;
        e.rd = rd; e.wr = wr; e.inc = inc; e.run = run;
        return e;
    endfunction

    function automatic exp_t mx(input logic [7:0] st, input logic [23:0] c);
        return mk(st, c, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    endfunction

    function automatic exp_t obs(input int d);
        return {o_ps[d], o_ctl[d], o_alu[d], o_rd[d], o_wr[d],
                o_inc[d], o_run[d]};
    endfunction

    task automatic check(input string tag, input exp_t e, input int d);
        exp_t o;
        o = obs(d);
        total++;
        assert (o === e) else begin
            bad++;
            $error("FAIL %s dut=%0d observed=%h expected=%h", tag, d, o, e);
        end
    endtask

    // Expected cycle list for one instruction, from the step tables.
    task automatic plan(input logic [31:0] w, input logic cf,
                        output bit halt);
        int         op;
        logic [3:0] cl;
        logic [4:0] a;
        op = int'(w[31:27]);
        q.delete();
        q.push_back(mk(8'h01, bm(B_PCOUT) | bm(B_MARIN), 5'd0,
                       1'b0, 1'b0, 1'b1, 1'b1));
        for (int k = 0; k <= mw; k++)
            q.push_back(mk(8'h02, (k == mw) ? bm(B_MDRIN) : 24'd0, 5'd0,
                           1'b1, 1'b0, 1'b0, 1'b1));
        q.push_back(mx(8'h03, bm(B_MDROUT) | bm(B_IRIN)));
        halt = (op == 27);
        if (halt) return;
        if (op >= 3 && op <= 11)       cl = 4'h1;
        else if (op >= 12 && op <= 14) cl = 4'h2;
        else if (op == 17 || op == 18) cl = 4'h3;
        else if (op == 15 || op == 16) cl = 4'h4;
        else if (op == 0)              cl = 4'h5;
        else if (op == 1)              cl = 4'h6;
        else if (op == 2)              cl = 4'h7;
        else if (op == 19)             cl = 4'h8;
        else if (op == 20)             cl = 4'h9;
        else if (op == 21)             cl = 4'hA;
        else if (op >= 22 && op <= 25) cl = 4'hB;
        else                           cl = 4'hC;
        a = (op == 12) ? 5'd3 : (op == 13) ? 5'd10 : 5'd11;
        case (cl)
            4'h1, 4'h2: begin
                q.push_back(mx({cl, 4'd3}, bm(B_GRB) | bm(B_ROUT) | bm(B_YIN)));
                if (cl == 4'h1)
                    q.push_back(mk({cl, 4'd4}, bm(B_GRC) | bm(B_ROUT) | bm(B_ZIN),
                                   5'(op), 1'b0, 1'b0, 1'b0, 1'b1));
                else
                    q.push_back(mk({cl, 4'd4}, bm(B_COUT) | bm(B_ZIN),
                                   a, 1'b0, 1'b0, 1'b0, 1'b1));
                q.push_back(mx({cl, 4'd5}, bm(B_ZLO) | bm(B_GRA) | bm(B_RIN)));
            end
            4'h3: begin
                q.push_back(mk({cl, 4'd3}, bm(B_GRB) | bm(B_ROUT) | bm(B_ZIN),
                               5'(op), 1'b0, 1'b0, 1'b0, 1'b1));
                q.push_back(mx({cl, 4'd4}, bm(B_ZLO) | bm(B_GRA) | bm(B_RIN)));
            end
            4'h4: begin
                q.push_back(mx({cl, 4'd3}, bm(B_GRA) | bm(B_ROUT) | bm(B_YIN)));
                q.push_back(mk({cl, 4'd4}, bm(B_GRB) | bm(B_ROUT) | bm(B_ZIN),
                               5'(op), 1'b0, 1'b0, 1'b0, 1'b1));
                q.push_back(mx({cl, 4'd5}, bm(B_ZLO) | bm(B_LOIN)));
                q.push_back(mx({cl, 4'd6}, bm(B_ZHI) | bm(B_HIIN)));
            end
            4'h5, 4'h6, 4'h7: begin
                q.push_back(mx({cl, 4'd3}, bm(B_GRB) | bm(B_BAOUT) | bm(B_YIN)));
                q.push_back(mk({cl, 4'd4}, bm(B_COUT) | bm(B_ZIN),
                               5'd3, 1'b0, 1'b0, 1'b0, 1'b1));
                if (cl == 4'h6) begin
                    q.push_back(mx({cl, 4'd5}, bm(B_ZLO) | bm(B_GRA) | bm(B_RIN)));
                end else begin
                    q.push_back(mx({cl, 4'd5}, bm(B_ZLO) | bm(B_MARIN)));
                    if (cl == 4'h5) begin
                        for (int k = 0; k <= mw; k++)
                            q.push_back(mk({cl, 4'd6},
                                           (k == mw) ? bm(B_MDRIN) : 24'd0,
                                           5'd0, 1'b1, 1'b0, 1'b0, 1'b1));
                        q.push_back(mx({cl, 4'd7},
                                       bm(B_MDROUT) | bm(B_GRA) | bm(B_RIN)));
                    end else begin
                        q.push_back(mx({cl, 4'd6},
                                       bm(B_GRA) | bm(B_ROUT) | bm(B_MDRIN)));
                        for (int k = 0; k <= mw; k++)
                            q.push_back(mk({cl, 4'd7}, 24'd0, 5'd0,
                                           1'b0, 1'b1, 1'b0, 1'b1));
                    end
                end
            end
            4'h8: begin
                q.push_back(mx({cl, 4'd3}, bm(B_GRA) | bm(B_ROUT) | bm(B_CONIN)));
                q.push_back(mx({cl, 4'd4}, bm(B_PCOUT) | bm(B_YIN)));
                q.push_back(mk({cl, 4'd5}, bm(B_COUT) | bm(B_ZIN),
                               5'd3, 1'b0, 1'b0, 1'b0, 1'b1));
                q.push_back(mx({cl, 4'd6}, cf ? (bm(B_ZLO) | bm(B_PCIN)) : 24'd0));
            end
            4'h9: q.push_back(mx({cl, 4'd3}, bm(B_GRA) | bm(B_ROUT) | bm(B_PCIN)));
            4'hA: begin
                q.push_back(mx({cl, 4'd3}, bm(B_PCOUT) | bm(B_GRB) | bm(B_RIN)));
                q.push_back(mx({cl, 4'd4}, bm(B_GRA) | bm(B_ROUT) | bm(B_PCIN)));
            end
            4'hB: begin
                if (op == 22)      q.push_back(mx(8'hB3, bm(B_INP) | bm(B_GRA) | bm(B_RIN)));
                else if (op == 23) q.push_back(mx(8'hB3, bm(B_GRA) | bm(B_ROUT) | bm(B_OUTP)));
                else if (op == 24) q.push_back(mx(8'hB3, bm(B_HIOUT) | bm(B_GRA) | bm(B_RIN)));
                else               q.push_back(mx(8'hB3, bm(B_LOOUT) | bm(B_GRA) | bm(B_RIN)));
            end
            default: q.push_back(mx(8'hC3, 24'd0));
        endcase
    endtask

    task automatic rst_assert(input int d);
        rst_n[d] = 1'b0;
        stop[d] = 1'b0;
        pend = 1'b0;
        #1 check("rst_async", '0, d);
    endtask

    task automatic rst_release(input int d);
        @(posedge clk);
        #1 rst_n[d] = 1'b1;
        @(negedge clk);
        check("rst_idle", '0, d);
    endtask

    // Stop is high for cycle indices [s_at, s_at+s_len) of this run,
    // counting the fetch/execute cycles and then any paused cycles.
    task automatic do_instr(input int d, input logic [31:0] w,
                            input logic cf, input int s_at,
                            input int s_len, input logic [7:0] abort_st);
        bit   h;
        int   n;
        int   i;
        logic s;
        @(posedge clk);
        #1;
        ir[d] = w;
        con[d] = cf;
        plan(w, cf, h);
        n = q.size();
        for (i = 0; i < n; i++) begin
            @(negedge clk);
            check($sformatf("st%02h_op%0d", q[i].st, w[31:27]), q[i], d);
            if (q[i].st == abort_st) begin
                #2 rst_assert(d);
                return;
            end
            s = (s_at >= 0 && i >= s_at && i < s_at + s_len);
            stop[d] = s;
            if (s) pend = 1'b1;
        end
        if (h) begin
            for (int k = 0; k < 6; k++) begin
                @(negedge clk);
                check("halted", mk(8'hFF, 24'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0), d);
                stop[d] = k[0];
            end
            stop[d] = 1'b0;
            return;
        end
        if (pend) begin
            pend = 1'b0;
            for (int k = 0; k < 64; k++) begin
                @(negedge clk);
                check("paused", mk(8'hFE, 24'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0), d);
                s = (s_at >= 0 && i >= s_at && i < s_at + s_len);
                stop[d] = s;
                i++;
                if (!s) break;
            end
        end
    endtask

    task automatic rand_run(input int d, input int cnt);
        logic [31:0] w;
        int          sa;
        int          sl;
        for (int k = 0; k < cnt; k++) begin
            w = $urandom;
            if (w[31:27] == 5'd27) w[31:27] = 5'd26;
            sa = -1;
            sl = 0;
            if ($urandom_range(0, 3) == 0) begin
                sa = $urandom_range(0, 9);
                sl = $urandom_range(1, 4);
            end
            do_instr(d, w, 1'($urandom), sa, sl, 8'h00);
        end
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            rst_n[d] = 1'b0;
            stop[d] = 1'b0;
            ir[d] = 32'h0;
            con[d] = 1'b0;
        end
        #12;

        mw = 0;
        check("rst_hold", '0, 0);
        rst_release(0);
        do_instr(0, 32'h18918000, 1'b0, -1, 0, 8'h00);
        do_instr(0, 32'h18918000, 1'b0, -1, 0, 8'h14);
        rst_release(0);
        do_instr(0, 32'h18918000, 1'b0, 4, 1, 8'h00);
        do_instr(0, 32'h18918000, 1'b0, 4, 7, 8'h00);
        do_instr(0, 32'h98800000, 1'b0, -1, 0, 8'h00);
        do_instr(0, 32'h98800000, 1'b1, -1, 0, 8'h00);
        do_instr(0, 32'h08900010, 1'b0, -1, 0, 8'h00);
        do_instr(0, 32'h10900008, 1'b0, -1, 0, 8'h00);
        do_instr(0, 32'h65100007, 1'b0, -1, 0, 8'h00);
        do_instr(0, 32'h7A100000, 1'b0, 0, 2, 8'h00);
        do_instr(0, 32'hAA100000, 1'b0, -1, 0, 8'h00);
        do_instr(0, 32'hB0800000, 1'b0, -1, 0, 8'h00);
        do_instr(0, 32'hC8800000, 1'b0, -1, 0, 8'h00);
        do_instr(0, 32'hE0000000, 1'b0, -1, 0, 8'h00);
        rand_run(0, 25);
        do_instr(0, 32'hD8000000, 1'b0, 2, 1, 8'h00);
        #3 rst_assert(0);
        rst_release(0);
        do_instr(0, 32'hD0000000, 1'b0, -1, 0, 8'h00);
        rst_n[0] = 1'b0;

        mw = 2;
        pend = 1'b0;
        rst_release(1);
        do_instr(1, 32'h00900004, 1'b0, -1, 0, 8'h00);
        do_instr(1, 32'h10900008, 1'b0, -1, 0, 8'h00);
        do_instr(1, 32'h18918000, 1'b0, 5, 2, 8'h00);
        do_instr(1, 32'h00900004, 1'b0, 8, 3, 8'h00);
        rand_run(1, 20);
        do_instr(1, 32'hD8000000, 1'b0, 4, 1, 8'h00);
        #3 rst_assert(1);
        rst_release(1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/control_unit.md
Name: control_unit

Overview:
- Moore-style sequencer for the single-bus CPU datapath.
- Runs the fetch, decode and execute step sequence for every instruction.
- Drives all register-enable, bus-select, memory, ALU-op and PC strobes.
- Reports its state on present_state for seven-segment/debug display, and implements Stop (pause) and the halt opcode.

Parameters:
- MEM_WAIT, 0, extra wait cycles per memory read/write (Read or Write held MEM_WAIT+1 cycles).
- WAIT_W, 4, width of the wait counter; MEM_WAIT < 2**WAIT_W.

Ports:
- Clock  in  1  system clock; all state updates on the rising edge.
- Reset  in  1  asynchronous, active-low reset.
- Stop  in  1  level; pause request, honoured at an instruction boundary.
- IR  in  32  instruction register contents; opcode IR[31:27], Ra [26:23], Rb [22:19], Rc [18:15].
- CON_FF  in  1  branch-condition flip-flop output.
- ctrl  out  24  strobe vector; bit map in the package: Gra Grb Grc Rin Rout BAout PCin PCout IRin MARin MDRin MDRout Yin Zin Zhighout Zlowout HIin LOin HIout LOout Cout InPortout OutPortin CONin.
- alu_op  out  5  ALU operation code.
- Read  out  1  memory read strobe.
- Write  out  1  memory write strobe.
- IncPC  out  1  PC increment.
- Run  out  1  1 while executing; 0 in reset, pause and halt.
- present_state  out  8  {class[3:0], step[3:0]}; special codes are 00 reset, 01/02/03 fetch T0/T1/T2, FE paused, FF halted.

Behaviour:
- Registers: state, wait counter, stop_pending.
- Reset=0 (async): present_state=00; ctrl, alu_op, Read, Write, IncPC, Run all 0; stop_pending=0. Reset mid-instruction abandons it.
- After release: one cycle in 00 (Run=0), then T0. Run=1 in every state except 00, FE and FF.
- Outputs decode combinationally from the registered state plus IR and are valid for the whole state cycle. IR is loaded at the end of T2; decode is used from T3.
- Fetch:
  - T0: PCout MARin IncPC.
  - T1: Read every wait cycle; MDRin only in the final cycle.
  - T2: MDRout IRin.
- Execute steps, by class:
  - 1 ALU3 (add sub shr shra shl ror rol and or): T3 Grb Rout Yin; T4 Grc Rout Zin alu_op=opcode; T5 Zlowout Gra Rin.
  - 2 ALUI (addi andi ori): T3 Grb Rout Yin; T4 Cout Zin alu_op=ADD/AND/OR; T5 Zlowout Gra Rin.
  - 3 ALU2 (neg not): T3 Grb Rout Zin alu_op=opcode; T4 Zlowout Gra Rin.
  - 4 MULDIV: T3 Gra Rout Yin; T4 Grb Rout Zin alu_op=opcode; T5 Zlowout LOin; T6 Zhighout HIin.
  - 5 LD: T3 Grb BAout Yin; T4 Cout Zin alu_op=ADD; T5 Zlowout MARin; T6 Read (wait; MDRin last cycle); T7 MDRout Gra Rin.
  - 6 LDI: T3 to T4 as LD; T5 Zlowout Gra Rin.
  - 7 ST: T3 to T5 as LD; T6 Gra Rout MDRin; T7 Write every wait cycle.
  - 8 BR: T3 Gra Rout CONin; T4 PCout Yin; T5 Cout Zin alu_op=ADD; T6 Zlowout PCin only if CON_FF=1, otherwise no strobes.
  - 9 JR: T3 Gra Rout PCin.
  - A JAL: T3 PCout Grb Rin; T4 Gra Rout PCin.
  - B MOVE: T3 only; in: InPortout Gra Rin; out: Gra Rout OutPortin; mfhi: HIout Gra Rin; mflo: LOout Gra Rin.
  - C NOP: T3 with no strobes. Undefined opcodes are treated as NOP.
- Halt opcode: T2 goes directly to FF.
- Last step of any class goes to T0, or to FE if stop_pending or Stop=1.
- Wait counter: loaded with MEM_WAIT on entry to a memory step, decrements each cycle; the state advances when the counter is 0. With MEM_WAIT=0 each memory step is one cycle.
- Stop:
  - Any Stop=1 cycle sets stop_pending; it clears on entry to FE.
  - FE stays while Stop=1; goes to T0 the cycle after Stop=0.
  - Stop is never honoured mid-instruction.
- FF is left only by Reset; Stop is ignored in FF.
- Simultaneous Stop and halt opcode: FF wins.
- ALU codes: ADD=00011, AND=01010, OR=01011. alu_op=0 outside Zin steps.

Decomposition:
- Package cpu_ctrl_pkg holds:
  - opcode constants: ld 00000, ldi 00001, st 00010, add 00011 … or 01011, addi 01100, andi 01101, ori 01110, mul 01111, div 10000, neg 10001, not 10010, br 10011, jr 10100, jal 10101, in 10110, out 10111, mfhi 11000, mflo 11001, nop 11010, halt 11011;
  - class codes 1 to C;
  - special state codes 00, 01, 02, 03, FE, FF;
  - ctrl bit indices.
- Sub-module instr_decoder: opcode in, class[3:0] and alu_op[4:0] out, purely combinational.

Test Plan:
1. Reset driven low during state 14 -> outputs 0 and present_state=00 immediately, no clock edge needed; release -> 00 for one cycle, then 01.
2. IR=32'h18918000 (add R1,R2,R3), MEM_WAIT=0 -> present_state 01,02,03,13,14,15,01; alu_op=00011 only in 14; Zlowout, Gra and Rin asserted in 15.
3. ld R1,4(R2) with MEM_WAIT=2 -> state 56 lasts 3 cycles with Read=1; MDRin=1 only in the third; 57 asserts MDRout Gra Rin.
4. br with CON_FF=0 -> state 86 has PCin=0; repeat with CON_FF=1 -> 86 has Zlowout=1 and PCin=1.
5. Stop pulsed for 1 cycle during 14 -> 15 completes, then FE with Run=0; Stop held 5 cycles in FE -> stays in FE; release -> 01 on the next cycle.
6. Halt opcode 11011 -> 01,02,03,FF; Run=0; Stop toggling keeps state FF; Reset pulse -> 00, then 01.
